interrupt_controller: RTL and testbench

Parametrised interrupt controller that replaces the processor's fixed two-line interrupt input with NUM_SRC maskable sources. It latches interrupt events, arbitrates by fixed priority, and presents a single request plus a service vector to the controller. It then tracks one in-service interrupt until the controller signals return. It sits between the external interrupt pins and the processor Controller's interrupt/fetch-redirect logic.

---
 rtl/interrupt_controller_if.sv | 44 ++++
 rtl/interrupt_controller.sv | 123 ++++++++++++
 tb/tb_interrupt_controller.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_controller_if.sv
// ----------------------------------------------------------------------------
// interrupt_controller_if
//   Bundle between the interrupt pins / processor controller and the
//   interrupt controller.
//   master : the processor side. Drives the interrupt lines, mask writes and
//            ack/done, and observes the request, vector and status.
//   slave  : the interrupt controller itself.
// Signals:
//   irq_in      interrupt lines, synchronous to clk
//   mask_we     mask register write enable
//   mask_wdata  new mask value (1 = source enabled)
//   int_ack     controller accepts the current request
//   int_done    controller executed return-from-interrupt
//   int_req     request to the controller
//   int_vec     service address of the current / in-service source
//   int_id      index of the current / in-service source
//   pending     latched pending bits (not masked)
//   mask        current mask register
// ----------------------------------------------------------------------------
interface interrupt_controller_if #(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = 16
);
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic               int_ack;
  logic               int_done;
  logic               int_req;
  logic [VEC_W-1:0]   int_vec;
  logic [3:0]         int_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_wdata, int_ack, int_done,
    input  int_req, int_vec, int_id, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_wdata, int_ack, int_done,
    output int_req, int_vec, int_id, pending, mask
  );
endinterface

// File: rtl/interrupt_controller.sv
// ----------------------------------------------------------------------------
// interrupt_controller
//   Latches events from NUM_SRC maskable interrupt sources, picks the lowest
//   enabled pending index, and presents one request plus its service vector.
//   It then tracks that single in-service source until the controller
//   signals return. Nesting is not supported.
// Ports:
//   clk    processor clock, all state on the rising edge
//   reset  asynchronous, active-low; clears all state immediately
//   bus    interrupt_controller_if.slave (lines, mask, ack/done, req/vec/id,
//          pending and mask status)
// Parameters:
//   NUM_SRC     number of sources (1..16)
//   VEC_W       vector width
//   VEC_BASE    vector of source 0
//   VEC_STRIDE  address distance between consecutive source vectors
//   EDGE_MODE   1 = rising-edge events latched, 0 = level-sensitive
// ----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int               NUM_SRC    = 4,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = 16'h0000,
  parameter int               VEC_STRIDE = 2,
  parameter bit               EDGE_MODE  = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] irq_prev;
  logic [NUM_SRC-1:0] pending_q, pending_nxt;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] set_evt;
  logic [NUM_SRC-1:0] clr_evt;
  logic [3:0]         id_q, win_id;
  logic [VEC_W-1:0]   vec_q, win_vec;
  logic               latch_win;
  logic               ack_fire;

  // Masking only gates arbitration; pending keeps the raw events.
  assign active = pending_q & mask_q;

  // Fixed priority: scan downward so the lowest set index is written last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) win_id = 4'(i);
    end
  end

  // Truncated to VEC_W bits: the vector wraps silently past the top.
  assign win_vec = VEC_BASE + VEC_W'(win_id) * VEC_W'(VEC_STRIDE);

  assign ack_fire = (state == REQ) && bus.int_ack;

  // Edge mode: a new rise in the same cycle as the ack clear wins, so the
  // OR with set_evt comes after the clear mask.
  assign set_evt     = bus.irq_in & ~irq_prev;
  assign clr_evt     = ack_fire ? (NUM_SRC'(1) << id_q) : '0;
  assign pending_nxt = EDGE_MODE ? ((pending_q & ~clr_evt) | set_evt)
                                 : bus.irq_in;

  always_comb begin
    state_nxt = state;
    latch_win = 1'b0;
    case (state)
      IDLE: begin
        if (|active) begin
          state_nxt = REQ;
          latch_win = 1'b1;
        end
      end
      REQ: begin
        // id/vector stay frozen here; the ack is the only way out.
        if (bus.int_ack) state_nxt = SERVICE;
      end
      SERVICE: begin
        if (bus.int_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      irq_prev  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      vec_q     <= '0;
    end else begin
      state     <= state_nxt;
      irq_prev  <= bus.irq_in;
      pending_q <= pending_nxt;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      if (latch_win) begin
        id_q  <= win_id;
        vec_q <= win_vec;
      end
    end
  end

  // All outputs come straight from registers.
  assign bus.int_req = (state == REQ);
  assign bus.int_id  = id_q;
  assign bus.int_vec = vec_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// ----------------------------------------------------------------------------
// tb_interrupt_controller
//   Three instances: default edge mode (m), level mode (l), wrapping vector
//   base (w). Expected grants are queued when the stimulus is applied and
//   popped when the matching DUT raises int_req.
// ----------------------------------------------------------------------------
module tb_interrupt_controller;

  typedef struct packed {
    logic [3:0]  id;
    logic [15:0] vec;
  } grant_t;

  grant_t exp_q[$];
  int     total = 0;
  int     bad   = 0;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_SRC(4), .VEC_W(16)) m_if ();
  interrupt_controller_if #(.NUM_SRC(4), .VEC_W(16)) l_if ();
  interrupt_controller_if #(.NUM_SRC(4), .VEC_W(16)) w_if ();

  interrupt_controller #(
    .NUM_SRC(4), .VEC_W(16), .VEC_BASE(16'h0000), .VEC_STRIDE(2), .EDGE_MODE(1'b1)
  ) dut_m (.clk(clk), .reset(reset), .bus(m_if));

  interrupt_controller #(
    .NUM_SRC(4), .VEC_W(16), .VEC_BASE(16'h0000), .VEC_STRIDE(2), .EDGE_MODE(1'b0)
  ) dut_l (.clk(clk), .reset(reset), .bus(l_if));

  interrupt_controller #(
    .NUM_SRC(4), .VEC_W(16), .VEC_BASE(16'hFFFE), .VEC_STRIDE(2), .EDGE_MODE(1'b1)
  ) dut_w (.clk(clk), .reset(reset), .bus(w_if));

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_irq(input int which, input logic [3:0] v);
    case (which)
      0:       m_if.irq_in = v;
      1:       l_if.irq_in = v;
      default: w_if.irq_in = v;
    endcase
  endtask

  task automatic write_mask(input int which, input logic [3:0] v);
    case (which)
      0:       begin m_if.mask_we = 1'b1; m_if.mask_wdata = v; end
      1:       begin l_if.mask_we = 1'b1; l_if.mask_wdata = v; end
      default: begin w_if.mask_we = 1'b1; w_if.mask_wdata = v; end
    endcase
    tick();
    m_if.mask_we = 1'b0;
    l_if.mask_we = 1'b0;
    w_if.mask_we = 1'b0;
  endtask

  task automatic pulse_ack(input int which);
    case (which)
      0:       m_if.int_ack = 1'b1;
      1:       l_if.int_ack = 1'b1;
      default: w_if.int_ack = 1'b1;
    endcase
    tick();
    m_if.int_ack = 1'b0;
    l_if.int_ack = 1'b0;
    w_if.int_ack = 1'b0;
  endtask

  task automatic pulse_done(input int which);
    case (which)
      0:       m_if.int_done = 1'b1;
      1:       l_if.int_done = 1'b1;
      default: w_if.int_done = 1'b1;
    endcase
    tick();
    m_if.int_done = 1'b0;
    l_if.int_done = 1'b0;
    w_if.int_done = 1'b0;
  endtask

  // Looks for int_req now and after each of up to budget-1 further edges.
  task automatic wait_req(input int which, input int budget, output bit ok,
                          output logic [3:0] id, output logic [15:0] vec);
    logic r;
    ok  = 1'b0;
    id  = 'x;
    vec = 'x;
    for (int c = 0; c < budget; c++) begin
      case (which)
        0:       begin r = m_if.int_req; id = m_if.int_id; vec = m_if.int_vec; end
        1:       begin r = l_if.int_req; id = l_if.int_id; vec = l_if.int_vec; end
        default: begin r = w_if.int_req; id = w_if.int_id; vec = w_if.int_vec; end
      endcase
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
      if (c < budget - 1) tick();
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    m_if.irq_in = '0; m_if.mask_we = 0; m_if.mask_wdata = '0; m_if.int_ack = 0; m_if.int_done = 0;
    l_if.irq_in = '0; l_if.mask_we = 0; l_if.mask_wdata = '0; l_if.int_ack = 0; l_if.int_done = 0;
    w_if.irq_in = '0; w_if.mask_we = 0; w_if.mask_wdata = '0; w_if.int_ack = 0; w_if.int_done = 0;
    reset = 1'b0;
    tick();
    tick();
    total++;
    if ({m_if.int_req, m_if.int_id, m_if.int_vec, m_if.pending, m_if.mask} !== '0) begin
      bad++;
      $display("FAIL reset_state: req=%b id=%0d vec=%h pending=%b mask=%b, required all zero",
               m_if.int_req, m_if.int_id, m_if.int_vec, m_if.pending, m_if.mask);
    end
    #3 reset = 1'b1;
    tick();
    write_mask(0, 4'b1111);
    write_mask(1, 4'b1111);
    write_mask(2, 4'b1111);
    total++;
    if (m_if.mask !== 4'b1111) begin
      bad++;
      $display("FAIL reset_mask_write: mask=%b required 1111", m_if.mask);
    end
  endtask

  task automatic test_basic();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    set_irq(0, 4'b0100);
    exp_q.push_back('{id: 4'd2, vec: 16'h0004});
    tick();
    set_irq(0, 4'b0000);
    total++;
    if (m_if.int_req !== 1'b0 || m_if.pending !== 4'b0100) begin
      bad++;
      $display("FAIL basic_first_edge: req=%b pending=%b required req=0 pending=0100",
               m_if.int_req, m_if.pending);
    end
    tick();
    wait_req(0, 1, ok, gid, gvec);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("FAIL basic_grant: req=%0b queued=%0d, required req on second edge", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({gid, gvec} !== {e.id, e.vec}) begin
        bad++;
        $display("FAIL basic_grant: id=%0d vec=%h required id=%0d vec=%h", gid, gvec, e.id, e.vec);
      end
    end
    pulse_done(0);  // ignored outside SERVICE
    total++;
    if (m_if.int_req !== 1'b1) begin
      bad++;
      $display("FAIL basic_done_in_req: req=%b required 1", m_if.int_req);
    end
    pulse_ack(0);
    total++;
    if (m_if.int_req !== 1'b0 || m_if.pending !== 4'b0000) begin
      bad++;
      $display("FAIL basic_ack: req=%b pending=%b required req=0 pending=0000",
               m_if.int_req, m_if.pending);
    end
    pulse_done(0);
    tick();
    total++;
    if (m_if.int_req !== 1'b0 || m_if.int_id !== 4'd2) begin
      bad++;
      $display("FAIL basic_idle: req=%b id=%0d required req=0 id=2", m_if.int_req, m_if.int_id);
    end
  endtask

  task automatic test_priority();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    set_irq(0, 4'b1010);
    exp_q.push_back('{id: 4'd1, vec: 16'h0002});
    tick();
    set_irq(0, 4'b0000);
    tick();
    wait_req(0, 1, ok, gid, gvec);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("FAIL prio_first: req=%0b queued=%0d", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({gid, gvec} !== {e.id, e.vec}) begin
        bad++;
        $display("FAIL prio_first: id=%0d vec=%h required id=%0d vec=%h", gid, gvec, e.id, e.vec);
      end
    end
    set_irq(0, 4'b0001);
    exp_q.push_back('{id: 4'd0, vec: 16'h0000});
    exp_q.push_back('{id: 4'd3, vec: 16'h0006});
    tick();
    set_irq(0, 4'b0000);
    tick();
    total++;
    if (m_if.int_req !== 1'b1 || m_if.int_id !== 4'd1 || m_if.int_vec !== 16'h0002 ||
        m_if.pending !== 4'b1011) begin
      bad++;
      $display("FAIL prio_freeze: req=%b id=%0d vec=%h pending=%b required 1/1/0002/1011",
               m_if.int_req, m_if.int_id, m_if.int_vec, m_if.pending);
    end
    pulse_ack(0);
    pulse_done(0);
    for (int k = 0; k < 2; k++) begin
      wait_req(0, 4, ok, gid, gvec);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++;
        $display("FAIL prio_next%0d: req=%0b queued=%0d", k, ok, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({gid, gvec} !== {e.id, e.vec}) begin
          bad++;
          $display("FAIL prio_next%0d: id=%0d vec=%h required id=%0d vec=%h",
                   k, gid, gvec, e.id, e.vec);
        end
      end
      pulse_ack(0);
      pulse_done(0);
    end
  endtask

  task automatic test_masking();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    write_mask(0, 4'b0000);
    set_irq(0, 4'b0010);
    tick();
    set_irq(0, 4'b0000);
    tick();
    tick();
    total++;
    if (m_if.pending !== 4'b0010 || m_if.int_req !== 1'b0) begin
      bad++;
      $display("FAIL mask_hold: pending=%b req=%b required pending=0010 req=0",
               m_if.pending, m_if.int_req);
    end
    write_mask(0, 4'b0010);
    total++;
    if (m_if.int_req !== 1'b0 || m_if.mask !== 4'b0010) begin
      bad++;
      $display("FAIL mask_write_edge: req=%b mask=%b required req=0 mask=0010",
               m_if.int_req, m_if.mask);
    end
    exp_q.push_back('{id: 4'd1, vec: 16'h0002});
    tick();
    wait_req(0, 1, ok, gid, gvec);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("FAIL mask_release: req=%0b queued=%0d", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({gid, gvec} !== {e.id, e.vec}) begin
        bad++;
        $display("FAIL mask_release: id=%0d vec=%h required id=%0d vec=%h", gid, gvec, e.id, e.vec);
      end
    end
    pulse_ack(0);
    pulse_done(0);
    write_mask(0, 4'b1111);
  endtask

  task automatic test_collision();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    set_irq(0, 4'b0100);
    exp_q.push_back('{id: 4'd2, vec: 16'h0004});
    tick();
    set_irq(0, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      wait_req(0, 4, ok, gid, gvec);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++;
        $display("FAIL collide_grant%0d: req=%0b queued=%0d", k, ok, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({gid, gvec} !== {e.id, e.vec}) begin
          bad++;
          $display("FAIL collide_grant%0d: id=%0d vec=%h required id=%0d vec=%h",
                   k, gid, gvec, e.id, e.vec);
        end
      end
      if (k == 0) begin
        // New rise of the same source on the ack edge: the set must win.
        set_irq(0, 4'b0100);
        exp_q.push_back('{id: 4'd2, vec: 16'h0004});
        pulse_ack(0);
        set_irq(0, 4'b0000);
        total++;
        if (m_if.pending !== 4'b0100 || m_if.int_req !== 1'b0) begin
          bad++;
          $display("FAIL collide_set_wins: pending=%b req=%b required pending=0100 req=0",
                   m_if.pending, m_if.int_req);
        end
      end else begin
        pulse_ack(0);
      end
      pulse_done(0);
    end
    total++;
    if (m_if.pending !== 4'b0000) begin
      bad++;
      $display("FAIL collide_clear: pending=%b required 0000", m_if.pending);
    end
  endtask

  task automatic test_level();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    set_irq(1, 4'b0001);
    exp_q.push_back('{id: 4'd0, vec: 16'h0000});
    for (int k = 0; k < 2; k++) begin
      wait_req(1, 4, ok, gid, gvec);
      total++;
      if (!ok || exp_q.size() == 0) begin
        bad++;
        $display("FAIL level_grant%0d: req=%0b queued=%0d", k, ok, exp_q.size());
      end else begin
        e = exp_q.pop_front();
        if ({gid, gvec} !== {e.id, e.vec}) begin
          bad++;
          $display("FAIL level_grant%0d: id=%0d vec=%h required id=%0d vec=%h",
                   k, gid, gvec, e.id, e.vec);
        end
      end
      pulse_ack(1);
      if (k == 0) begin
        total++;
        if (l_if.pending !== 4'b0001 || l_if.int_req !== 1'b0) begin
          bad++;
          $display("FAIL level_ack_keeps: pending=%b req=%b required pending=0001 req=0",
                   l_if.pending, l_if.int_req);
        end
        exp_q.push_back('{id: 4'd0, vec: 16'h0000});
        pulse_done(1);  // line still high: must re-request
      end else begin
        set_irq(1, 4'b0000);
        tick();
        pulse_done(1);
      end
    end
    tick();
    tick();
    total++;
    if (l_if.int_req !== 1'b0 || l_if.pending !== 4'b0000) begin
      bad++;
      $display("FAIL level_dropped: req=%b pending=%b required req=0 pending=0000",
               l_if.int_req, l_if.pending);
    end
  endtask

  task automatic test_wrap();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    set_irq(2, 4'b0010);
    exp_q.push_back('{id: 4'd1, vec: 16'h0000});
    tick();
    set_irq(2, 4'b0000);
    wait_req(2, 4, ok, gid, gvec);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("FAIL wrap_grant: req=%0b queued=%0d", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({gid, gvec} !== {e.id, e.vec}) begin
        bad++;
        $display("FAIL wrap_grant: id=%0d vec=%h required id=%0d vec=%h", gid, gvec, e.id, e.vec);
      end
    end
    pulse_ack(2);
    pulse_done(2);
  endtask

  task automatic test_async_reset();
    bit ok; logic [3:0] gid; logic [15:0] gvec; grant_t e;
    set_irq(0, 4'b1000);
    exp_q.push_back('{id: 4'd3, vec: 16'h0006});
    tick();
    set_irq(0, 4'b0000);
    wait_req(0, 4, ok, gid, gvec);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("FAIL areset_setup: req=%0b queued=%0d", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({gid, gvec} !== {e.id, e.vec}) begin
        bad++;
        $display("FAIL areset_setup: id=%0d vec=%h required id=%0d vec=%h", gid, gvec, e.id, e.vec);
      end
    end
    pulse_ack(0);
    set_irq(0, 4'b0010);  // latches only: no nesting in SERVICE
    tick();
    set_irq(0, 4'b0001);  // held high through reset
    // Between edges: outputs must clear with no clock edge.
    #2 reset = 1'b0;
    #1;
    total++;
    if ({m_if.int_req, m_if.int_id, m_if.int_vec, m_if.pending, m_if.mask} !== '0) begin
      bad++;
      $display("FAIL areset_immediate: req=%b id=%0d vec=%h pending=%b mask=%b required all zero",
               m_if.int_req, m_if.int_id, m_if.int_vec, m_if.pending, m_if.mask);
    end
    m_if.mask_we    = 1'b1;
    m_if.mask_wdata = 4'b1111;
    #3 reset = 1'b1;
    tick();
    m_if.mask_we = 1'b0;
    exp_q.push_back('{id: 4'd0, vec: 16'h0000});
    tick();
    wait_req(0, 1, ok, gid, gvec);
    total++;
    if (!ok || exp_q.size() == 0) begin
      bad++;
      $display("FAIL areset_high_line: req=%0b queued=%0d", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if ({gid, gvec} !== {e.id, e.vec}) begin
        bad++;
        $display("FAIL areset_high_line: id=%0d vec=%h required id=%0d vec=%h",
                 gid, gvec, e.id, e.vec);
      end
    end
    pulse_ack(0);
    set_irq(0, 4'b0000);
    pulse_done(0);
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_masking();
    test_collision();
    test_level();
    test_wrap();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d grants outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
